// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver (common anode, active-low drive).
// Digits are shadowed once per scan frame so a displayed frame never mixes old and new values.
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV   = 100000,
    parameter int unsigned DIV_WIDTH     = 17,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [3:0] DIGIT0,
    input  logic [3:0] DIGIT1,
    input  logic [3:0] DIGIT2,
    input  logic [3:0] DIGIT3,
    input  logic [3:0] DP_IN,
    output logic [3:0] SEG_SELECT,
    output logic [6:0] SEG_OUT,
    output logic       DP_OUT,
    output logic       FRAME_STROBE
);

    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(REFRESH_DIV - 1);

    logic [DIV_WIDTH-1:0] presc_q, presc_d;
    logic [1:0]           idx_q, idx_d;
    logic [3:0][3:0]      shadow_q, shadow_d;
    logic [3:0]           shadow_dp_q, shadow_dp_d;
    logic                 load_pending_q, load_pending_d;
    logic [3:0]           sel_q, sel_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_out_q, dp_out_d;
    logic                 strobe_q, strobe_d;

    logic       tick;
    logic       wrap;
    logic       load;
    logic [3:0] blank;
    logic [3:0] cur_digit;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    // Next-state and output decode; outputs reflect index/shadow held before the edge
    always_comb begin
        tick           = (presc_q == DIV_LAST);
        wrap           = tick && (idx_q == 2'd3);
        load           = wrap || load_pending_q;

        presc_d        = tick ? '0 : presc_q + DIV_WIDTH'(1);
        idx_d          = tick ? idx_q + 2'd1 : idx_q;
        shadow_d       = load ? {DIGIT3, DIGIT2, DIGIT1, DIGIT0} : shadow_q;
        shadow_dp_d    = load ? DP_IN : shadow_dp_q;
        load_pending_d = 1'b0;
        strobe_d       = wrap;

        // A digit may only blank if every digit to its left is blank too
        blank[3]  = BLANK_LEADING && (shadow_q[3] == 4'd0) && !shadow_dp_q[3];
        blank[2]  = blank[3] && (shadow_q[2] == 4'd0) && !shadow_dp_q[2];
        blank[1]  = blank[2] && (shadow_q[1] == 4'd0) && !shadow_dp_q[1];
        blank[0]  = 1'b0;

        cur_digit = shadow_q[idx_q];
        sel_d     = ~(4'b0001 << idx_q);
        seg_d     = blank[idx_q] ? 7'h7F : seg_decode(cur_digit);
        dp_out_d  = blank[idx_q] ? 1'b1 : ~shadow_dp_q[idx_q];
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            presc_q        <= '0;
            idx_q          <= 2'd0;
            shadow_q       <= '0;
            shadow_dp_q    <= 4'd0;
            load_pending_q <= 1'b1;
            sel_q          <= 4'b1111;
            seg_q          <= 7'h7F;
            dp_out_q       <= 1'b1;
            strobe_q       <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            idx_q          <= idx_d;
            shadow_q       <= shadow_d;
            shadow_dp_q    <= shadow_dp_d;
            load_pending_q <= load_pending_d;
            sel_q          <= sel_d;
            seg_q          <= seg_d;
            dp_out_q       <= dp_out_d;
            strobe_q       <= strobe_d;
        end
    end

    assign SEG_SELECT   = sel_q;
    assign SEG_OUT      = seg_q;
    assign DP_OUT       = dp_out_q;
    assign FRAME_STROBE = strobe_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed scoreboard bench for seg7_scan_driver: one instance without and one
// with leading-zero blanking, sharing all inputs, REFRESH_DIV=4.
module tb_seg7_scan_driver;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [3:0] d0, d1, d2, d3, dp;
    logic [3:0] a_sel, b_sel;
    logic [6:0] a_seg, b_seg;
    logic       a_dp, b_dp, a_fs, b_fs;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        bit          inst;
        logic [12:0] val;
    } exp_t;

    exp_t q[$];

    always #5 CLK = ~CLK;

    seg7_scan_driver #(.REFRESH_DIV(4), .DIV_WIDTH(2), .BLANK_LEADING(1'b0)) u_a (
        .CLK(CLK), .RESET_N(RESET_N),
        .DIGIT0(d0), .DIGIT1(d1), .DIGIT2(d2), .DIGIT3(d3), .DP_IN(dp),
        .SEG_SELECT(a_sel), .SEG_OUT(a_seg), .DP_OUT(a_dp), .FRAME_STROBE(a_fs)
    );

    seg7_scan_driver #(.REFRESH_DIV(4), .DIV_WIDTH(2), .BLANK_LEADING(1'b1)) u_b (
        .CLK(CLK), .RESET_N(RESET_N),
        .DIGIT0(d0), .DIGIT1(d1), .DIGIT2(d2), .DIGIT3(d3), .DP_IN(dp),
        .SEG_SELECT(b_sel), .SEG_OUT(b_seg), .DP_OUT(b_dp), .FRAME_STROBE(b_fs)
    );

    function automatic void push(string tag, bit inst, logic [3:0] sel, logic [6:0] seg,
                                 logic dpe, logic fs);
        exp_t e;
        e.tag  = tag;
        e.inst = inst;
        e.val  = {sel, seg, dpe, fs};
        q.push_back(e);
    endfunction

    function automatic void push_digit(string tag, bit inst, int idx, logic [6:0] seg,
                                       logic dpe, logic fs);
        logic [3:0] one;
        one = 4'b0001;
        push(tag, inst, ~(one << idx), seg, dpe, fs);
    endfunction

    function automatic void push_reset(string tag);
        push({tag, "_a"}, 1'b0, 4'b1111, 7'h7F, 1'b1, 1'b0);
        push({tag, "_b"}, 1'b1, 4'b1111, 7'h7F, 1'b1, 1'b0);
    endfunction

    task automatic check_all();
        exp_t        e;
        logic [12:0] obs;
        while (q.size() > 0) begin
            e   = q.pop_front();
            obs = e.inst ? {b_sel, b_seg, b_dp, b_fs} : {a_sel, a_seg, a_dp, a_fs};
            total++;
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s sel/seg/dp/fs observed=%h_%h_%b_%b expected=%h_%h_%b_%b",
                       e.tag, obs[12:9], obs[8:2], obs[1], obs[0],
                       e.val[12:9], e.val[8:2], e.val[1], e.val[0]);
            end
        end
    endtask

    task automatic clk_check();
        @(posedge CLK);
        #1;
        check_all();
    endtask

    initial begin
        RESET_N = 1'b0;
        d3 = 4'd4; d2 = 4'd3; d1 = 4'd2; d0 = 4'd1; dp = 4'd0;
        @(posedge CLK);
        #1;
        push_reset("por");
        check_all();
        @(negedge CLK);
        RESET_N = 1'b1;

        // Scan 4,3,2,1 without blanking; DIGIT0 changes while digit 2 is lit
        for (int k = 1; k <= 20; k++) begin
            int         idx;
            logic [6:0] s;
            idx = ((k - 1) / 4) % 4;
            case (idx)
                0:       s = (k == 1) ? 7'h40 : ((k > 16) ? 7'h78 : 7'h79);
                1:       s = 7'h24;
                2:       s = 7'h30;
                default: s = 7'h19;
            endcase
            if (k == 10) d0 = 4'd7;
            push_digit($sformatf("scanA_k%0d", k), 1'b0, idx, s, 1'b1, k == 16);
            if (k == 2 || k == 8) push_digit($sformatf("scanB_k%0d", k), 1'b1, idx, s, 1'b1, 1'b0);
            clk_check();
        end

        // Asynchronous reset mid-frame, held for three edges
        d3 = 4'd0; d2 = 4'd0; d1 = 4'd5; d0 = 4'd0; dp = 4'd0;
        #3;
        RESET_N = 1'b0;
        #1;
        push_reset("async_rst");
        check_all();
        for (int i = 0; i < 3; i++) begin
            push_reset($sformatf("rst_hold%0d", i));
            clk_check();
        end
        @(negedge CLK);
        RESET_N = 1'b1;

        // 0,0,5,0 with and without blanking; then DP on digit 2; then DIGIT1=C
        for (int k = 1; k <= 56; k++) begin
            int         idx;
            logic       fs;
            logic [6:0] sa, sb;
            logic       pa, pb;
            idx = ((k - 1) / 4) % 4;
            fs  = (k % 16 == 0);
            if (k == 17) dp = 4'b0100;
            if (k == 41) d1 = 4'hC;
            pa = 1'b1;
            pb = 1'b1;
            case (idx)
                0: begin sa = 7'h40; sb = 7'h40; end
                1: begin
                    sa = (k <= 48) ? 7'h12 : 7'h3F;
                    sb = sa;
                end
                2: begin
                    sa = 7'h40;
                    sb = (k <= 32) ? 7'h7F : 7'h40;
                    pa = (k <= 32);
                    pb = (k <= 32);
                end
                default: begin sa = 7'h40; sb = 7'h7F; end
            endcase
            push_digit($sformatf("postA_k%0d", k), 1'b0, idx, sa, pa, fs);
            push_digit($sformatf("postB_k%0d", k), 1'b1, idx, sb, pb, fs);
            clk_check();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Consumes the BCD digit values produced by the chain of cascaded generic counters and drives a 4-digit, common-anode, multiplexed seven-segment display. A refresh prescaler scans one digit at a time. Digit values are captured into shadow registers once per full scan frame, so the display never tears. Options provide leading-zero blanking, decimal points and an invalid-BCD indicator.

Parameters:
REFRESH_DIV, 100000, clock cycles each digit stays lit (1 kHz digit rate at 100 MHz); must be >= 2
DIV_WIDTH, 17, prescaler width; must satisfy 2^DIV_WIDTH >= REFRESH_DIV
BLANK_LEADING, 1, 1 = blank leading zeros on digits 3..1; 0 = show all digits

Ports:
CLK  input  1  system clock, all state on rising edge
RESET_N  input  1  reset, asynchronous, active-low
DIGIT0  input  4  BCD, rightmost digit (least significant)
DIGIT1  input  4  BCD
DIGIT2  input  4  BCD
DIGIT3  input  4  BCD, leftmost digit (most significant)
DP_IN  input  4  decimal point request per digit, bit n = digit n, active-high
SEG_SELECT  output  4  anode enables, active-low, bit n = digit n
SEG_OUT  output  7  cathodes, active-low, bit0=a ... bit6=g
DP_OUT  output  1  decimal-point cathode, active-low
FRAME_STROBE  output  1  one-cycle pulse per completed scan frame

Behaviour:
- Reset (RESET_N=0, takes effect immediately, no clock needed):
  - prescaler=0, digit index=0, shadow digits=0, shadow DP=0, load_pending=1.
  - SEG_SELECT=4'b1111, SEG_OUT=7'h7F, DP_OUT=1, FRAME_STROBE=0.
- Prescaler: counts 0..REFRESH_DIV-1, then wraps to 0. tick=1 on the cycle where prescaler==REFRESH_DIV-1.
- Digit index:
  - advances 0->1->2->3->0 on the edge where tick=1; otherwise holds.
  - each index value therefore lasts exactly REFRESH_DIV cycles.
- Shadow load: DIGIT0..3 and DP_IN are sampled into the shadow registers on either of these edges:
  - the edge where index wraps 3->0;
  - the first edge after reset release (load_pending=1; load_pending then clears).
  - Inputs are ignored at all other times. Mid-frame input changes are not displayed until the next load.
- FRAME_STROBE:
  - registered; high for exactly one cycle after each edge on which index wraps 3->0.
  - not asserted for the post-reset load.
- Output registers:
  - On every edge, SEG_SELECT, SEG_OUT and DP_OUT load the decode of the index and shadow values held before that edge.
  - Visible outputs therefore lag index/shadow changes by one cycle.
  - SEG_SELECT drives a 0 on bit[index] only.
- Segment decode (shadow value -> SEG_OUT):
  - 0->7'h40, 1->7'h79, 2->7'h24, 3->7'h30, 4->7'h19
  - 5->7'h12, 6->7'h02, 7->7'h78, 8->7'h00, 9->7'h10
  - 10..15 -> 7'h3F (dash, segment g only)
- DP_OUT = ~shadow_DP[index].
- Leading-zero blanking (BLANK_LEADING=1), evaluated on shadow values:
  - blank3 = (d3==0) && !dp3
  - blank2 = blank3 && (d2==0) && !dp2
  - blank1 = blank2 && (d1==0) && !dp1
  - digit 0 is never blanked.
  - A blanked digit still has its anode selected, with SEG_OUT=7'h7F and DP_OUT=1.
  - With BLANK_LEADING=0, no digit is ever blanked.
- Reset mid-frame: all state returns to reset values at once. Scanning restarts at digit 0 with a fresh shadow load on the first edge after release.

Test Plan:
1. REFRESH_DIV=4. Pulse RESET_N low between clock edges -> outputs go to 1111/7F/1/0 without waiting for an edge. After release, first digit-0 output appears on edge 2.
2. DIGIT3..0=4,3,2,1, DP_IN=0, BLANK_LEADING=0 -> SEG_SELECT cycles 1110,1101,1011,0111, each held 4 cycles, with SEG_OUT 79,24,30,19 respectively. FRAME_STROBE pulses every 16 cycles.
3. Change DIGIT0 from 1 to 7 while digit 2 is lit -> digit 0 shows 7'h79 until after the next FRAME_STROBE, then shows 7'h78.
4. BLANK_LEADING=1, DIGIT3..0=0,0,5,0, DP_IN=0 -> digits 3 and 2 show 7F; digit 1 shows 12; digit 0 shows 40.
5. Same as scenario 4 but DP_IN=4'b0100 -> digit 2 shows 40 with DP_OUT=0 and digit 3 stays blank. Then DIGIT1=4'hC -> digit 1 shows 3F.
6. Hold RESET_N low for 3 cycles mid-frame, then release -> index restarts at 0. The next FRAME_STROBE arrives exactly 16 cycles after the first post-release edge.
